mux_arbiter_rr: RTL

- Transmit-side scheduler for the 4-channel mux/demux datapath.
- Drains four source FIFOs in round-robin order and drives the shared word stream plus the selector that the far-end demux uses to pick a destination.
- Destination is the same channel index as the source (channel i feeds demux output i).
- Honours per-destination almost-full back-pressure from the demux side.

---
 rtl/mux_arbiter_rr_pkg.sv | 19 +
 rtl/mux_arbiter_rr_grant4.sv | 41 ++++
 rtl/mux_arbiter_rr.sv | 113 +++++++++++
 3 files changed

// File: rtl/mux_arbiter_rr_pkg.sv
// Shared constants, FSM state encoding and helpers for the 4-channel transmit scheduler.
// The companion RTL honours the optional MUX_ARB_STRICT_PRIO_EN build macro.
package mux_arbiter_rr_pkg;

  localparam int NUM_CH    = 4;
  localparam int SEL_WIDTH = $clog2(NUM_CH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_STALL  = 2'b10
  } state_t;

  function automatic logic [NUM_CH-1:0] sel_to_onehot(input logic [SEL_WIDTH-1:0] sel);
    sel_to_onehot      = '0;
    sel_to_onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/mux_arbiter_rr_grant4.sv
// Combinational 4-way grant picker: round-robin from last_grant+1, or fixed priority
// 0 > 1 > 2 > 3 when MUX_ARB_STRICT_PRIO_EN is defined.
module rr_grant4
  import mux_arbiter_rr_pkg::*;
(
  input  logic [NUM_CH-1:0]    eligible,
  input  logic [SEL_WIDTH-1:0] last_grant,
  output logic                 grant_valid,
  output logic [SEL_WIDTH-1:0] grant
);

`ifdef MUX_ARB_STRICT_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  always_comb begin
    grant_valid = |eligible;
    grant       = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (eligible[i]) grant = SEL_WIDTH'(i);
    end
  end
`else
  logic [SEL_WIDTH-1:0] cand;

  // Walk offsets from farthest to nearest so the channel right after last_grant wins.
  always_comb begin
    grant_valid = 1'b0;
    grant       = last_grant;
    cand        = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = last_grant + SEL_WIDTH'(k);
      if (eligible[cand]) begin
        grant_valid = 1'b1;
        grant       = cand;
      end
    end
  end
`endif

endmodule

// File: rtl/mux_arbiter_rr.sv
// Transmit-side scheduler: drains four source FIFOs onto one word stream plus selector,
// honouring per-destination almost-full. Build macro MUX_ARB_STRICT_PRIO_EN selects fixed priority.
module mux_arbiter_rr #(
  parameter int DATA_WIDTH = 4,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  enb,
  input  logic [3:0]            fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data0,
  input  logic [DATA_WIDTH-1:0] fifo_data1,
  input  logic [DATA_WIDTH-1:0] fifo_data2,
  input  logic [DATA_WIDTH-1:0] fifo_data3,
  input  logic [3:0]            dest_almost_full,
  output logic [3:0]            fifo_pop,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [SEL_WIDTH-1:0]  out_sel,
  output logic                  out_valid,
  output logic [1:0]            estado
);

  import mux_arbiter_rr_pkg::*;

  logic [NUM_CH-1:0]    eligible;
  logic                 any_src;
  logic                 grant_valid;
  logic [SEL_WIDTH-1:0] grant;
  logic [SEL_WIDTH-1:0] last_grant;
  logic [SEL_WIDTH-1:0] sel_p1;
  logic                 vld_p1;
  logic [DATA_WIDTH-1:0] fifo_word;
  state_t               state_q;
  state_t               state_d;

  // reset_L gating keeps the pop strobes quiet the instant reset is asserted.
  assign eligible = {NUM_CH{enb & reset_L}} & ~fifo_empty & ~dest_almost_full;
  assign any_src  = ~&fifo_empty;

  rr_grant4 u_grant (
    .eligible    (eligible),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  assign fifo_pop = grant_valid ? sel_to_onehot(grant) : '0;

`ifdef MUX_ARB_STRICT_PRIO_EN
  assign last_grant = '1;
`else
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)         last_grant <= '1;
    else if (grant_valid) last_grant <= grant;
  end
`endif

  // Stage p1: pop issued last cycle, FIFO read data arrives this cycle.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      sel_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= grant_valid;
      if (grant_valid) sel_p1 <= grant;
    end
  end

  always_comb begin
    case (sel_p1)
      2'd0:    fifo_word = fifo_data0;
      2'd1:    fifo_word = fifo_data1;
      2'd2:    fifo_word = fifo_data2;
      default: fifo_word = fifo_data3;
    endcase
  end

  // Output stage: word and selector captured together; both hold while idle.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_data <= fifo_word;
        out_sel  <= sel_p1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state depends only on this cycle's condition, never on the current state.
  always_comb begin
    state_d = ST_IDLE;
    if (grant_valid)          state_d = ST_ACTIVE;
    else if (enb && any_src)  state_d = ST_STALL;
  end

  always_comb begin
    case (state_q)
      ST_ACTIVE: estado = ST_ACTIVE;
      ST_STALL:  estado = ST_STALL;
      default:   estado = ST_IDLE;
    endcase
  end

endmodule
